// File: rtl/alu_multiciclo_pkg.sv
// Shared opcode and FSM state definitions for the multicycle ALU.
package alu_multiciclo_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_XOR   = 4'd3,
      OP_NOR   = 4'd4,
      OP_SLL   = 4'd5,
      OP_SRL   = 4'd6,
      OP_SRA   = 4'd7,
      OP_SUB   = 4'd8,
      OP_MULTU = 4'd9,
      OP_MULT  = 4'd10,
      OP_DIVU  = 4'd11,
      OP_DIV   = 4'd12,
      OP_SLT   = 4'd13,
      OP_SLTU  = 4'd14,
      OP_INV   = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // True for the ops that go through the iterative datapath
   function automatic logic is_muldiv(input alu_op_e op);
      return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_multiciclo_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
module alu_multiciclo_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_div,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);
   localparam int unsigned CW = $clog2(WIDTH);

   logic [WIDTH-1:0]   r_acc, r_q, r_m;
   logic [CW-1:0]      r_cnt;
   logic               r_div, r_neg_q, r_neg_r;

   logic               w_sa, w_sb, w_ge;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_diff;
   logic [WIDTH:0]     w_sum, w_shl;
   logic [2*WIDTH-1:0] w_prod;

   assign w_sa    = i_signed & i_a[WIDTH-1];
   assign w_sb    = i_signed & i_b[WIDTH-1];
   assign w_abs_a = w_sa ? -i_a : i_a;
   assign w_abs_b = w_sb ? -i_b : i_b;

   // Multiply: add multiplicand when the LSB of the multiplier is set, then shift right
   assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
   // Divide: shift next dividend bit into the partial remainder, subtract if it fits
   assign w_shl  = {r_acc, r_q[WIDTH-1]};
   assign w_ge   = (w_shl >= {1'b0, r_m});
   assign w_diff = WIDTH'(w_shl - {1'b0, r_m});
   assign w_prod = {r_acc, r_q};
   assign o_last = (r_cnt == '0);

   // Load magnitudes and signs, then one iteration per step strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_q     <= '0;
         r_m     <= '0;
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (i_load) begin
         r_acc   <= '0;
         r_q     <= w_abs_a;
         r_m     <= w_abs_b;
         r_cnt   <= CW'(WIDTH-1);
         r_div   <= i_div;
         r_neg_q <= w_sa ^ w_sb;
         r_neg_r <= w_sa;
      end else if (i_step) begin
         r_cnt <= r_cnt - CW'(1);
         if (r_div) begin
            if (w_ge) begin
               r_acc <= w_diff;
               r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
               r_acc <= w_shl[WIDTH-1:0];
               r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            r_acc <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
         end
      end
   end

   // Sign correction of the final product / quotient / remainder
   always_comb begin
      o_lo = '0;
      o_hi = '0;
      if (r_div) begin
         o_lo = r_neg_q ? -r_q   : r_q;
         o_hi = r_neg_r ? -r_acc : r_acc;
      end else begin
         {o_hi, o_lo} = r_neg_q ? -w_prod : w_prod;
      end
   end

endmodule

// File: rtl/alu_multiciclo.sv
// Multicycle EX-stage ALU: single-cycle logic/arith ops plus iterative mul/div.
module alu_multiciclo
   import alu_multiciclo_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUOperation,
   output logic [WIDTH-1:0] ALUResult,
   output logic [WIDTH-1:0] HI,
   output logic             Zero,
   output logic             Overflow,
   output logic             DivByZero,
   output logic             Busy,
   output logic             Done
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           r_state, w_next;
   alu_op_e          w_op;
   logic [WIDTH-1:0] r_result, r_hi, r_a;
   logic             r_zero, r_ovf, r_dz, r_busy, r_done, r_md_dz, r_md_ovf;
   logic [WIDTH-1:0] w_result_d, w_hi_d, w_alu_res, w_md_lo, w_md_hi, w_add, w_sub;
   logic             w_ovf_d, w_dz_d, w_alu_ovf, w_accept, w_load, w_step, w_last;
   logic             w_is_div, w_signed, w_b_zero;
   logic [SHW-1:0]   w_shamt;

   assign w_op     = alu_op_e'(ALUOperation);
   assign w_accept = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_is_div = (w_op == OP_DIVU) || (w_op == OP_DIV);
   assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
   assign w_b_zero = (B == '0);
   assign w_shamt  = B[SHW-1:0];
   assign w_add    = A + B;
   assign w_sub    = A - B;

   assign ALUResult = r_result;
   assign HI        = r_hi;
   assign Zero      = r_zero;
   assign Overflow  = r_ovf;
   assign DivByZero = r_dz;
   assign Busy      = r_busy;
   assign Done      = r_done;

   alu_multiciclo_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (reset),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_div    (w_is_div),
      .i_signed (w_signed),
      .i_a      (A),
      .i_b      (B),
      .o_last   (w_last),
      .o_lo     (w_md_lo),
      .o_hi     (w_md_hi)
   );

   // Single-cycle result and signed add/sub overflow
   always_comb begin
      w_alu_res = '0;
      w_alu_ovf = 1'b0;
      case (w_op)
         OP_AND:  w_alu_res = A & B;
         OP_OR:   w_alu_res = A | B;
         OP_XOR:  w_alu_res = A ^ B;
         OP_NOR:  w_alu_res = ~(A | B);
         OP_SLL:  w_alu_res = A << w_shamt;
         OP_SRL:  w_alu_res = A >> w_shamt;
         OP_SRA:  w_alu_res = WIDTH'($signed(A) >>> w_shamt);
         OP_SLT:  w_alu_res = WIDTH'($signed(A) < $signed(B));
         OP_SLTU: w_alu_res = WIDTH'(A < B);
         OP_ADD: begin
            w_alu_res = w_add;
            w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_res = w_sub;
            w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
         end
         default: w_alu_res = '0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state, datapath strobes and next output values
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_step     = 1'b0;
      w_result_d = r_result;
      w_hi_d     = r_hi;
      w_ovf_d    = r_ovf;
      w_dz_d     = r_dz;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (r_state == S_DONE) w_next = S_IDLE;
            if (w_accept) begin
               if (is_muldiv(w_op)) begin
                  w_load = 1'b1;
                  w_next = (w_is_div && w_b_zero) ? S_FIX : S_RUN;
               end else begin
                  w_next     = S_DONE;
                  w_result_d = w_alu_res;
                  w_hi_d     = '0;
                  w_ovf_d    = w_alu_ovf;
                  w_dz_d     = 1'b0;
               end
            end
         end
         S_RUN: begin
            w_step = 1'b1;
            if (w_last) w_next = S_FIX;
         end
         S_FIX: begin
            w_next = S_DONE;
            if (r_md_dz) begin
               w_result_d = '1;
               w_hi_d     = r_a;
               w_ovf_d    = 1'b0;
               w_dz_d     = 1'b1;
            end else begin
               w_result_d = w_md_lo;
               w_hi_d     = w_md_hi;
               w_ovf_d    = r_md_ovf;
               w_dz_d     = 1'b0;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Registered outputs and per-operation side information
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_result <= '0;
         r_hi     <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_a      <= '0;
         r_md_dz  <= 1'b0;
         r_md_ovf <= 1'b0;
      end else begin
         r_result <= w_result_d;
         r_hi     <= w_hi_d;
         r_zero   <= (w_result_d == '0);
         r_ovf    <= w_ovf_d;
         r_dz     <= w_dz_d;
         r_busy   <= (w_next == S_RUN) || (w_next == S_FIX);
         r_done   <= (w_next == S_DONE);
         if (w_load) begin
            r_a      <= A;
            r_md_dz  <= w_is_div && w_b_zero;
            r_md_ovf <= (w_op == OP_DIV) && (A == MIN_VAL) && (B == '1);
         end
      end
   end

endmodule
